// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// ram_arb_pkg : shared types for the two-master RAM port arbiter
// Rev 1.0
// ============================================================================
package ram_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_M0   = 2'd1,
      ARB_M1   = 2'd2
   } arb_state_t;

   typedef enum logic {
      MST_CPU = 1'b0,
      MST_DBG = 1'b1
   } mst_id_t;

   localparam logic [3:0] BE_NONE = 4'h0;

endpackage
`default_nettype wire

// File: rtl/ram_arb_pick.sv
`default_nettype none
// ============================================================================
// ram_arb_pick : 2-way round-robin winner select (combinational)
// Rev 1.0
// ============================================================================
module ram_arb_pick
   import ram_arb_pkg::*;
(
   input  logic    elig0,
   input  logic    elig1,
   input  mst_id_t last,
   output logic    any,
   output mst_id_t winner
);

   always_comb begin
      any    = elig0 | elig1;
      winner = MST_CPU;
      // On contention the master that did not own the port most recently wins
      if (elig0 && elig1)
         winner = (last == MST_CPU) ? MST_DBG : MST_CPU;
      else if (elig1)
         winner = MST_DBG;
   end

endmodule
`default_nettype wire

// File: rtl/ram_arb.sv
`default_nettype none
// ============================================================================
// ram_arb : req/gnt arbiter sharing one sync-read RAM port between CPU and
//           debug loader. Optional counters enabled by RAM_ARB_PERF_EN.
// Rev 1.0
// ============================================================================
module ram_arb
   import ram_arb_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MAX_BURST = 16
)(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            cpu_rst_n_i,
   input  logic            m0_req_i,
   input  logic            m0_we_i,
   input  logic [XLEN-1:0] m0_addr_i,
   input  logic [XLEN-1:0] m0_wr_data_i,
   input  logic [3:0]      m0_byte_en_i,
   output logic            m0_gnt_o,
   output logic [XLEN-1:0] m0_rd_data_o,
   output logic            m0_rd_vld_o,
   input  logic            m1_req_i,
   input  logic            m1_we_i,
   input  logic [XLEN-1:0] m1_addr_i,
   input  logic [XLEN-1:0] m1_wr_data_i,
   input  logic [3:0]      m1_byte_en_i,
   input  logic            m1_lock_i,
   output logic            m1_gnt_o,
   output logic [XLEN-1:0] m1_rd_data_o,
   output logic            m1_rd_vld_o,
   output logic [XLEN-1:0] ram_rd_addr_o,
   output logic [XLEN-1:0] ram_wr_addr_o,
   output logic [XLEN-1:0] ram_wr_data_o,
   output logic [3:0]      ram_wr_byte_en_o,
   input  logic [XLEN-1:0] ram_rd_data_i,
   output logic [31:0]     perf_m0_beats_o,
   output logic [31:0]     perf_m1_beats_o,
   output logic [31:0]     perf_m1_wait_o
);

   localparam int               CNT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

   arb_state_t       state, state_nxt;
   mst_id_t          last, last_nxt;
   logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
   logic             rd_pend;
   mst_id_t          rd_id;

   logic             elig0, elig1;
   logic             pick_any;
   mst_id_t          pick_winner;
   logic             any_gnt;
   logic             beat_we;
   logic [XLEN-1:0]  beat_addr;
   logic [XLEN-1:0]  beat_data;
   logic [3:0]       beat_be;

   assign elig0 = m0_req_i & cpu_rst_n_i;
   assign elig1 = m1_req_i;

   ram_arb_pick u_pick (
      .elig0  (elig0),
      .elig1  (elig1),
      .last   (last),
      .any    (pick_any),
      .winner (pick_winner)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= ARB_IDLE;
         last     <= MST_DBG;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      last_nxt     = last;
      beat_cnt_nxt = beat_cnt;
      m0_gnt_o     = 1'b0;
      m1_gnt_o     = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (pick_any)
               state_nxt = (pick_winner == MST_CPU) ? ARB_M0 : ARB_M1;
         end
         ARB_M0: begin
            m0_gnt_o = elig0;
            if (!elig0) begin
               state_nxt    = ARB_IDLE;
               last_nxt     = MST_CPU;
               beat_cnt_nxt = '0;
            end else if (beat_cnt == BURST_LAST) begin
               // Count saturates so a late M1 request still cuts the burst short
               if (m1_req_i) begin
                  state_nxt    = ARB_IDLE;
                  last_nxt     = MST_CPU;
                  beat_cnt_nxt = '0;
               end
            end else begin
               beat_cnt_nxt = beat_cnt + 1'b1;
            end
         end
         ARB_M1: begin
            m1_gnt_o = elig1;
            if (!m1_req_i && !m1_lock_i) begin
               state_nxt = ARB_IDLE;
               last_nxt  = MST_DBG;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_comb begin
      beat_we   = 1'b0;
      beat_addr = '0;
      beat_data = '0;
      beat_be   = BE_NONE;
      case (state)
         ARB_M0: begin
            beat_we   = m0_we_i;
            beat_addr = m0_addr_i;
            beat_data = m0_wr_data_i;
            beat_be   = m0_byte_en_i;
         end
         ARB_M1: begin
            beat_we   = m1_we_i;
            beat_addr = m1_addr_i;
            beat_data = m1_wr_data_i;
            beat_be   = m1_byte_en_i;
         end
         default: ;
      endcase
   end

   assign any_gnt          = m0_gnt_o | m1_gnt_o;
   assign ram_rd_addr_o    = beat_addr;
   assign ram_wr_addr_o    = beat_addr;
   assign ram_wr_data_o    = beat_data;
   assign ram_wr_byte_en_o = (any_gnt && beat_we) ? beat_be : BE_NONE;

   // Tag of the read in flight steers the returning RAM data to its requester
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_pend <= 1'b0;
         rd_id   <= MST_CPU;
      end else begin
         rd_pend <= any_gnt & ~beat_we;
         if (any_gnt)
            rd_id <= m1_gnt_o ? MST_DBG : MST_CPU;
      end
   end

   assign m0_rd_vld_o  = rd_pend & (rd_id == MST_CPU);
   assign m1_rd_vld_o  = rd_pend & (rd_id == MST_DBG);
   assign m0_rd_data_o = m0_rd_vld_o ? ram_rd_data_i : '0;
   assign m1_rd_data_o = m1_rd_vld_o ? ram_rd_data_i : '0;

`ifdef RAM_ARB_PERF_EN
   logic [31:0] perf_m0, perf_m1, perf_wait;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_m0   <= '0;
         perf_m1   <= '0;
         perf_wait <= '0;
      end else begin
         if (m0_gnt_o)
            perf_m0 <= perf_m0 + 32'd1;
         if (m1_gnt_o)
            perf_m1 <= perf_m1 + 32'd1;
         if (m1_req_i && !m1_gnt_o)
            perf_wait <= perf_wait + 32'd1;
      end
   end

   assign perf_m0_beats_o = perf_m0;
   assign perf_m1_beats_o = perf_m1;
   assign perf_m1_wait_o  = perf_wait;
`else
   assign perf_m0_beats_o = '0;
   assign perf_m1_beats_o = '0;
   assign perf_m1_wait_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_arb.sv
`default_nettype none
// ============================================================================
// tb_ram_arb : randomized + directed bench for ram_arb with a behavioural
//              ownership/RAM model. Rev 1.0
// ============================================================================
module tb_ram_arb;

   localparam int MAX_BURST = 16;

   logic        clk = 1'b0;
   logic        rst, cpu_rst_n;
   logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_be, m1_be;
   logic        m0_gnt, m0_rd_vld, m1_gnt, m1_rd_vld;
   logic [31:0] m0_rd_data, m1_rd_data;
   logic [31:0] ram_rd_addr, ram_wr_addr, ram_wr_data, ram_rd_data;
   logic [3:0]  ram_wr_byte_en;
   logic [31:0] perf_m0_beats, perf_m1_beats, perf_m1_wait;

   always #5 clk = ~clk;

   ram_arb #(.XLEN(32), .MAX_BURST(MAX_BURST)) dut (
      .clk_i(clk), .rst_i(rst), .cpu_rst_n_i(cpu_rst_n),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
      .m0_wr_data_i(m0_wdata), .m0_byte_en_i(m0_be),
      .m0_gnt_o(m0_gnt), .m0_rd_data_o(m0_rd_data), .m0_rd_vld_o(m0_rd_vld),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
      .m1_wr_data_i(m1_wdata), .m1_byte_en_i(m1_be), .m1_lock_i(m1_lock),
      .m1_gnt_o(m1_gnt), .m1_rd_data_o(m1_rd_data), .m1_rd_vld_o(m1_rd_vld),
      .ram_rd_addr_o(ram_rd_addr), .ram_wr_addr_o(ram_wr_addr),
      .ram_wr_data_o(ram_wr_data), .ram_wr_byte_en_o(ram_wr_byte_en),
      .ram_rd_data_i(ram_rd_data),
      .perf_m0_beats_o(perf_m0_beats), .perf_m1_beats_o(perf_m1_beats),
      .perf_m1_wait_o(perf_m1_wait)
   );

   // RAM macro stand-in: byte-enable write, one-cycle registered read
   logic [31:0] mem [0:63];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) mem[i] <= '0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (ram_wr_byte_en[b]) mem[ram_wr_addr[7:2]][8*b +: 8] <= ram_wr_data[8*b +: 8];
      end
      ram_rd_data <= mem[ram_rd_addr[7:2]];
   end

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } txn_t;

   txn_t q0[$];
   txn_t q1[$];

   int n_checks, n_errors;
   int cyc, ev_cyc;

   // reference model state
   int          holder;     // -1 nobody, 0 CPU, 1 loader
   int          prev;       // most recent owner
   int          run_len;    // beats in current CPU tenure
   bit          pend;
   int          pend_who;
   logic [31:0] pend_data;
   logic [31:0] ref_mem [0:63];
   int unsigned p_m0, p_m1, p_wait;
   bit          x_e0, x_e1, x_g0, x_g1, x_v0, x_v1;
   bit          obs_g0, obs_g1, obs_v0, obs_v1;
   logic [31:0] obs_d1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic txn_t mk(input bit we, input int idx, input logic [31:0] d, input logic [3:0] be);
      txn_t t;
      t.we   = we;
      t.addr = 32'(idx) << 2;
      t.data = d;
      t.be   = be;
      return t;
   endfunction

   function automatic txn_t rand_txn();
      return mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
   endfunction

   task automatic model_reset();
      holder  = -1;
      prev    = 1;
      run_len = 0;
      pend    = 0;
      p_m0    = 0;
      p_m1    = 0;
      p_wait  = 0;
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
   endtask

   task automatic drive();
      m0_req = (q0.size() > 0);
      m1_req = (q1.size() > 0);
      if (m0_req) begin
         m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].data; m0_be = q0[0].be;
      end else begin
         m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_be = 4'h0;
      end
      if (m1_req) begin
         m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].data; m1_be = q1[0].be;
      end else begin
         m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_be = 4'h0;
      end
   endtask

   task automatic evaluate();
      logic [3:0]  xbe;
      logic        bwe;
      logic [31:0] badr, bdat;
      ev_cyc = cyc;
      x_e0 = m0_req && cpu_rst_n;
      x_e1 = m1_req;
      x_g0 = !rst && holder == 0 && x_e0;
      x_g1 = !rst && holder == 1 && x_e1;
      x_v0 = !rst && pend && pend_who == 0;
      x_v1 = !rst && pend && pend_who == 1;
      xbe  = 4'h0;
      if (x_g0 && m0_we) xbe = m0_be;
      else if (x_g1 && m1_we) xbe = m1_be;
      obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_v0 = m0_rd_vld; obs_v1 = m1_rd_vld;
      obs_d1 = m1_rd_data;
      check("m0_gnt", {31'd0, m0_gnt}, {31'd0, x_g0});
      check("m1_gnt", {31'd0, m1_gnt}, {31'd0, x_g1});
      check("m0_rd_vld", {31'd0, m0_rd_vld}, {31'd0, x_v0});
      check("m1_rd_vld", {31'd0, m1_rd_vld}, {31'd0, x_v1});
      check("m0_rd_data", m0_rd_data, x_v0 ? pend_data : 32'h0);
      check("m1_rd_data", m1_rd_data, x_v1 ? pend_data : 32'h0);
      check("ram_byte_en", {28'd0, ram_wr_byte_en}, {28'd0, xbe});
      if (x_g0 || x_g1) begin
         bwe  = x_g0 ? m0_we : m1_we;
         badr = x_g0 ? m0_addr : m1_addr;
         bdat = x_g0 ? m0_wdata : m1_wdata;
         if (bwe) begin
            check("ram_wr_addr", ram_wr_addr, badr);
            check("ram_wr_data", ram_wr_data, bdat);
         end else begin
            check("ram_rd_addr", ram_rd_addr, badr);
         end
      end
`ifdef RAM_ARB_PERF_EN
      check("perf_m0_beats", perf_m0_beats, p_m0);
      check("perf_m1_beats", perf_m1_beats, p_m1);
      check("perf_m1_wait", perf_m1_wait, p_wait);
`else
      check("perf_m0_tied", perf_m0_beats, 32'h0);
      check("perf_m1_tied", perf_m1_beats, 32'h0);
      check("perf_wait_tied", perf_m1_wait, 32'h0);
`endif
   endtask

   task automatic commit();
      bit          bwe;
      int          idx;
      logic [31:0] bdat;
      logic [3:0]  bbe;
      if (rst) begin
         model_reset();
         return;
      end
      if (x_g0) p_m0++;
      if (x_g1) p_m1++;
      if (m1_req && !x_g1) p_wait++;
      pend = 0;
      if (x_g0 || x_g1) begin
         bwe  = x_g0 ? m0_we : m1_we;
         idx  = int'(x_g0 ? m0_addr[7:2] : m1_addr[7:2]);
         bdat = x_g0 ? m0_wdata : m1_wdata;
         bbe  = x_g0 ? m0_be : m1_be;
         if (bwe) begin
            for (int b = 0; b < 4; b++)
               if (bbe[b]) ref_mem[idx][8*b +: 8] = bdat[8*b +: 8];
         end else begin
            pend      = 1;
            pend_who  = x_g1 ? 1 : 0;
            pend_data = ref_mem[idx];
         end
      end
      case (holder)
         -1: begin
            if (x_e0 && x_e1) holder = (prev == 0) ? 1 : 0;
            else if (x_e0)    holder = 0;
            else if (x_e1)    holder = 1;
         end
         0: begin
            if (x_g0) run_len++;
            if (!x_e0 || (m1_req && run_len >= MAX_BURST)) begin
               holder = -1; prev = 0; run_len = 0;
            end
         end
         default: begin
            if (!m1_req && !m1_lock) begin
               holder = -1; prev = 1;
            end
         end
      endcase
      if (x_g0) q0.delete(0);
      if (x_g1) q1.delete(0);
   endtask

   task automatic cycle();
      drive();
      @(negedge clk);
      evaluate();
      @(posedge clk);
      commit();
      cyc++;
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && (q0.size() > 0 || q1.size() > 0); i++) cycle();
      if (q0.size() > 0 || q1.size() > 0) check("drain_timeout", 32'd1, 32'd0);
      repeat (3) cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      q0.delete();
      q1.delete();
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, first, n_m0, last_g0, first_g1, nv;
      bit pushed;
      int unsigned p_start;

      n_checks = 0; n_errors = 0; cyc = 0;
      rst = 1'b1; cpu_rst_n = 1'b1; m1_lock = 1'b0;
      model_reset();
      drive();
      repeat (3) cycle();
      rst = 1'b0;
      repeat (10) cycle();

      // loader owns the RAM while the CPU is held in reset
      cpu_rst_n = 1'b0;
      q0.push_back(mk(0, 1, 0, 0));
      q1.push_back(mk(1, 4, 32'hDEADBEEF, 4'hF));
      q1.push_back(mk(0, 4, 0, 0));
      t0 = cyc; first = -1;
      for (int i = 0; i < 10 && q1.size() > 0; i++) begin
         cycle();
         if (obs_g1 && first < 0) first = ev_cyc;
      end
      if (q1.size() > 0) check("m1_load_timeout", 32'd1, 32'd0);
      check("m1_first_gnt_latency", 32'(first - t0), 32'd1);
      cycle();
      check("m1_readback_vld", {31'd0, obs_v1}, 32'd1);
      check("m1_readback_data", obs_d1, 32'hDEADBEEF);
      q0.delete();
      cpu_rst_n = 1'b1;
      repeat (3) cycle();

      // simultaneous requests out of reset: CPU wins
      do_reset();
      q0.push_back(mk(0, 2, 0, 0));
      q1.push_back(mk(0, 3, 0, 0));
      for (int i = 0; i < 5 && !(obs_g0 || obs_g1); i++) cycle();
      check("first_winner_m0", {31'd0, obs_g0}, 32'd1);
      check("first_winner_not_m1", {31'd0, obs_g1}, 32'd0);
      drain();

      // fairness bound: 40 CPU reads against a waiting loader
      for (int i = 0; i < 16; i++) q0.push_back(mk(1, i, $urandom, 4'hF));
      drain();
      p_start = p_m0;
      for (int i = 0; i < 40; i++) q0.push_back(mk(0, i % 16, 0, 0));
      n_m0 = 0; last_g0 = -1; first_g1 = -1; pushed = 0;
      for (int i = 0; i < 300 && (q0.size() > 0 || q1.size() > 0); i++) begin
         if (n_m0 == 1 && !pushed) begin
            q1.push_back(mk(0, 7, 0, 0));
            pushed = 1;
         end
         cycle();
         if (obs_g1 && first_g1 < 0) first_g1 = ev_cyc;
         if (obs_g0 && first_g1 < 0) begin n_m0++; last_g0 = ev_cyc; end
      end
      check("burst_len_m0", 32'(n_m0), 32'd16);
      check("burst_switch_gap", 32'(first_g1 - last_g0), 32'd2);
`ifdef RAM_ARB_PERF_EN
      check("perf_m0_burst40", perf_m0_beats - p_start, 32'd40);
`endif
      drain();

      // loader lock holds ownership across request gaps
      m1_lock = 1'b1;
      q1.push_back(mk(1, 5, $urandom, 4'h3));
      q1.push_back(mk(1, 6, $urandom, 4'hC));
      cycle();
      for (int i = 0; i < 3; i++) q0.push_back(mk(0, 5 + i, 0, 0));
      n_m0 = 0;
      repeat (8) begin cycle(); if (obs_g0) n_m0++; end
      q1.push_back(mk(0, 5, 0, 0));
      q1.push_back(mk(0, 6, 0, 0));
      repeat (6) begin cycle(); if (obs_g0) n_m0++; end
      check("lock_blocks_m0", 32'(n_m0), 32'd0);
      m1_lock = 1'b0;
      t0 = cyc; first = -1;
      for (int i = 0; i < 10 && first < 0; i++) begin
         cycle();
         if (obs_g0) first = ev_cyc;
      end
      check("lock_release_to_m0", 32'(first - t0), 32'd2);
      drain();

      // CPU reset asserted right after a granted read
      for (int i = 0; i < 6; i++) q0.push_back(mk(0, i, 0, 0));
      first = -1;
      for (int i = 0; i < 10 && first < 0; i++) begin
         cycle();
         if (obs_g0) first = ev_cyc;
      end
      if (first < 0) check("cpu_rst_setup_timeout", 32'd1, 32'd0);
      cpu_rst_n = 1'b0;
      cycle();
      check("cpu_rst_gnt_drop", {31'd0, obs_g0}, 32'd0);
      check("cpu_rst_rd_vld_completes", {31'd0, obs_v0}, 32'd1);
      nv = 0;
      repeat (3) begin cycle(); if (obs_v0) nv++; end
      check("cpu_rst_no_extra_vld", 32'(nv), 32'd0);
      cpu_rst_n = 1'b1;
      drain();

      // asynchronous reset with a read outstanding
      for (int i = 0; i < 4; i++) q0.push_back(mk(0, i, 0, 0));
      first = -1;
      for (int i = 0; i < 10 && first < 0; i++) begin
         cycle();
         if (obs_g0) first = ev_cyc;
      end
      rst = 1'b1;
      #1;
      check("async_rst_gnt", {31'd0, m0_gnt}, 32'd0);
      check("async_rst_vld", {31'd0, m0_rd_vld}, 32'd0);
      check("async_rst_be", {28'd0, ram_wr_byte_en}, 32'd0);
      model_reset();
      q0.delete();
      q1.delete();
      cycle();
      cycle();
      rst = 1'b0;
      repeat (2) cycle();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if (q0.size() < 3 && $urandom_range(0, 2) == 0) q0.push_back(rand_txn());
         if (q1.size() < 3 && $urandom_range(0, 3) == 0) q1.push_back(rand_txn());
         if ($urandom_range(0, 19) == 0) m1_lock = ~m1_lock;
         if ($urandom_range(0, 29) == 0) cpu_rst_n = ~cpu_rst_n;
         cycle();
      end
      m1_lock = 1'b0;
      cpu_rst_n = 1'b1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
